// File: rtl/pa_f_spsram_init_wrap_pkg.sv
// Shared constants for the initialising single-port SRAM wrapper:
// sweep FSM encoding and the default fill value.
package pa_f_spsram_init_wrap_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } init_state_e;

  // Every bit of the default sweep word takes this value.
  localparam logic INIT_FILL_BIT = 1'b0;

endpackage

// File: rtl/pa_f_spsram_array.sv
// Behavioural FPGA storage: one write port with per-bit enables and an
// asynchronous read of an externally registered address.
module pa_f_spsram_array #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 38
) (
  input  logic                  cpuclk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_bit_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;

  assign old_word = mem[wr_addr];

  // Masked bits keep the stored value so the array needs only whole-word writes.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_merge
      assign merged_word[gi] = wr_bit_en[gi] ? wr_data[gi] : old_word[gi];
    end
  endgenerate

  always_ff @(posedge cpuclk) begin
    if (wr_en) begin
      mem[wr_addr] <= merged_word;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pa_f_spsram_init_wrap.sv
// Single-port SRAM wrapper with ASIC-style macro pins, a hardware init sweep
// (after reset and on request), busy/done status and an optional Q register.
module pa_f_spsram_init_wrap
  import pa_f_spsram_init_wrap_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 9,
  parameter int                    DATA_WIDTH    = 38,
  parameter bit                    OUT_REG       = 1'b0,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = {DATA_WIDTH{INIT_FILL_BIT}}
) (
  input  logic                  cpuclk,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  init_done
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  init_state_e             state_reg;
  logic [ADDR_WIDTH:0]     cnt_reg;
  logic [ADDR_WIDTH-1:0]   addr_hold_reg;
  logic                    init_done_reg;

  logic                    cen_int;
  logic                    arr_wr_en;
  logic [ADDR_WIDTH-1:0]   arr_wr_addr;
  logic [DATA_WIDTH-1:0]   arr_wr_data;
  logic [DATA_WIDTH-1:0]   arr_wr_bit_en;
  logic [DATA_WIDTH-1:0]   arr_rd_data;

  assign init_busy = (state_reg == INIT);
  assign init_done = init_done_reg;

  // Functional accesses are blocked for the whole sweep.
  assign cen_int       = CEN | init_busy;
  assign arr_wr_en     = init_busy | (~cen_int & ~GWEN);
  assign arr_wr_addr   = init_busy ? cnt_reg[ADDR_WIDTH-1:0] : A;
  assign arr_wr_data   = init_busy ? INIT_VALUE : D;
  assign arr_wr_bit_en = init_busy ? {DATA_WIDTH{1'b1}} : ~WEN;

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg     <= INIT_ON_RESET ? INIT : IDLE;
      cnt_reg       <= '0;
      addr_hold_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      init_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!cen_int) begin
            addr_hold_reg <= A;
          end
          if (init_req) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
          end
        end
        INIT: begin
          cnt_reg <= cnt_reg + CNT_ONE;
          if (cnt_reg == LAST_ADDR) begin
            state_reg     <= IDLE;
            init_done_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  pa_f_spsram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .cpuclk    (cpuclk),
    .wr_en     (arr_wr_en),
    .wr_addr   (arr_wr_addr),
    .wr_data   (arr_wr_data),
    .wr_bit_en (arr_wr_bit_en),
    .rd_addr   (addr_hold_reg),
    .rd_data   (arr_rd_data)
  );

  generate
    if (OUT_REG) begin : g_q_reg
      logic [DATA_WIDTH-1:0] q_reg;
      always_ff @(posedge cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
          q_reg <= '0;
        end else begin
          q_reg <= arr_rd_data;
        end
      end
      assign Q = q_reg;
    end else begin : g_q_comb
      assign Q = arr_rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_pa_f_spsram_init_wrap.sv
// Drives one OUT_REG=0 and one OUT_REG=1 wrapper with shared directed
// stimulus and checks both against a transaction-level memory model.
module tb_pa_f_spsram_init_wrap;

  localparam int AW    = 4;
  localparam int DW    = 38;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic          init_req;
  logic [DW-1:0] q0, q1;
  logic          busy0, busy1, done0, done1;

  int checks   = 0;
  int failures = 0;

  pa_f_spsram_init_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b0), .INIT_ON_RESET(1'b1)) dut0 (
    .cpuclk(clk), .cpurst_b(rst_n), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(q0), .init_req(init_req), .init_busy(busy0), .init_done(done0)
  );

  pa_f_spsram_init_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1'b1), .INIT_ON_RESET(1'b1)) dut1 (
    .cpuclk(clk), .cpurst_b(rst_n), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
    .Q(q1), .init_req(init_req), .init_busy(busy1), .init_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, last accessed address and a sweep
  // countdown, advanced once per clock from the sampled pins.
  logic [DW-1:0] mem_m [DEPTH];
  logic          busy_m, done_m, q1_valid;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] q1_m;
  int            left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m    <= 1'b1;
      left      <= DEPTH;
      done_m    <= 1'b0;
      last_addr <= '0;
      q1_valid  <= 1'b0;
      q1_m      <= '0;
    end else begin
      q1_m     <= mem_m[last_addr];
      q1_valid <= !busy_m;
      done_m   <= 1'b0;
      if (busy_m) begin
        mem_m[DEPTH - left] <= '0;
        left <= left - 1;
        if (left == 1) begin
          busy_m <= 1'b0;
          done_m <= 1'b1;
        end
      end else begin
        if (!CEN) begin
          last_addr <= A;
          if (!GWEN) mem_m[A] <= (mem_m[A] & WEN) | (D & ~WEN);
        end
        if (init_req) begin
          busy_m <= 1'b1;
          left   <= DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy0", 64'(busy0), 64'(busy_m));
    chk("busy1", 64'(busy1), 64'(busy_m));
    chk("done0", 64'(done0), 64'(done_m));
    chk("done1", 64'(done1), 64'(done_m));
    if (!busy_m) chk("model_q0", 64'(q0), 64'(mem_m[last_addr]));
    if (q1_valid) chk("model_q1", 64'(q1), 64'(q1_m));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_pins();
    CEN = 1'b1; GWEN = 1'b1; WEN = ALL1; D = '0; init_req = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] wen);
    CEN = 1'b0; GWEN = 1'b0; A = a; D = d; WEN = wen;
    tick();
    idle_pins();
    $display("WR  A=%0d D=%h WEN=%h", a, d, wen);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] r0, output logic [DW-1:0] r1);
    CEN = 1'b0; GWEN = 1'b1; A = a;
    tick();
    idle_pins();
    r0 = q0;
    tick();
    r1 = q1;
    $display("RD  A=%0d Q0=%h Q1=%h", a, r0, r1);
  endtask

  task automatic count_busy(output int n, output int dones);
    n = 0; dones = 0;
    while (busy0 && n < 100) begin
      if (done0) dones++;
      tick();
      n++;
    end
    $display("SWEEP busy_cycles=%0d early_done=%0d", n, dones);
  endtask

  task automatic check_sweep_end(input string tag, input int n, input int dones);
    chk({tag, "_len"}, 64'(n), 64'd16);
    chk({tag, "_early_done"}, 64'(dones), 64'd0);
    chk({tag, "_done_hi"}, 64'(done0), 64'd1);
    tick();
    chk({tag, "_done_lo"}, 64'(done0), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] r0, r1;
    int n, dones;
    idle_pins();
    A = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_q1", 64'(q1), 64'd0);
    rst_n = 1'b1;

    // 1: sweep after reset release, then every address reads zero
    count_busy(n, dones);
    check_sweep_end("t1", n, dones);
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a), r0, r1);
      chk("t1_rd_q0", 64'(r0), 64'd0);
      chk("t1_rd_q1", 64'(r1), 64'd0);
    end

    // 2: per-bit write mask
    wr(4'd5, 38'h3F_FFFF_FFFF, '0);
    wr(4'd5, '0, 38'h3F_FFFF_FF00);
    rd(4'd5, r0, r1);
    chk("t2_q0", 64'(r0), 64'h3F_FFFF_FF00);
    chk("t2_q1", 64'(r1), 64'h3F_FFFF_FF00);

    // 3: latency and hold while CEN=1
    wr(4'd7, 38'h12345, '0);
    rd(4'd5, r0, r1);
    CEN = 1'b0; GWEN = 1'b1; A = 4'd7;
    tick();
    idle_pins();
    chk("t3_q0_lat1", 64'(q0), 64'h12345);
    chk("t3_q1_lat1_old", 64'(q1), 64'h3F_FFFF_FF00);
    for (int i = 0; i < 10; i++) begin
      A = AW'($urandom_range(0, DEPTH - 1));
      GWEN = 1'($urandom); WEN = DW'({$urandom, $urandom}); D = DW'({$urandom, $urandom});
      tick();
      chk("t3_hold_q0", 64'(q0), 64'h12345);
      chk("t3_hold_q1", 64'(q1), 64'h12345);
      $display("HOLD cycle=%0d A=%0d Q0=%h Q1=%h", i, A, q0, q1);
    end
    idle_pins();

    // 4: requested sweep with dropped writes and a re-request at cycle 3
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), DW'(a * 3 + 1), '0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    n = 0; dones = 0;
    while (busy0 && n < 100) begin
      CEN = 1'b0; GWEN = 1'b0; WEN = '0; D = ALL1; A = AW'(n);
      init_req = (n == 3);
      if (done0) dones++;
      tick();
      n++;
    end
    idle_pins();
    $display("SWEEP busy_cycles=%0d early_done=%0d", n, dones);
    check_sweep_end("t4", n, dones);
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a), r0, r1);
      chk("t4_rd_q0", 64'(r0), 64'd0);
      chk("t4_rd_q1", 64'(r1), 64'd0);
    end

    // 5: reset aborts a sweep at cycle 6; a full sweep follows release
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    count_busy(n, dones);
    check_sweep_end("t5", n, dones);

    // 6: write and init request on the same edge
    wr(4'd2, 38'h5, '0);
    CEN = 1'b0; GWEN = 1'b0; A = 4'd2; D = 38'h1; WEN = '0; init_req = 1'b1;
    tick();
    idle_pins();
    count_busy(n, dones);
    check_sweep_end("t6", n, dones);
    rd(4'd2, r0, r1);
    chk("t6_q0", 64'(r0), 64'd0);
    chk("t6_q1", 64'(r1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
